imm_gen_stage: RTL
==================

Name: imm_gen_stage

Overview:
Registered, parametrised immediate-generation stage sitting between fetch and decode/execute. It accepts instructions with their PC over a valid/ready handshake and decodes the immediate, format code and illegal flag at push time. Results are held in a small FIFO and presented to the consumer with a valid/ready handshake. It generalises the combinational immediate decoder to XLEN=32/64 and adds correct shift-amount handling, CSR zimm, illegal detection, buffering and flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; immediates sign-/zero-extended to XLEN.
DEPTH, 2, FIFO entries; power of two, 1..8.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  discard all buffered entries and any same-cycle input
in_valid  in  1  producer has an instruction
in_ready  out  1  stage can accept (registered: FIFO not full)
in_ir  in  32  instruction word
in_pc  in  XLEN  instruction PC
out_valid  out  1  head entry valid (FIFO not empty)
out_ready  in  1  consumer takes head
out_ir  out  32  head instruction
out_pc  out  XLEN  head PC
out_imm  out  XLEN  decoded immediate
out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM
out_illegal  out  1  unsupported encoding

Behaviour:
- Push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- Reset: count=0, rd/wr pointers=0, in_ready=1, out_valid=0, all head fields read 0 (storage cleared).
- Latency: entry pushed in cycle N visible at outputs in N+1. No combinational path in_valid->out_valid or out_ready->in_ready.
- in_ready = (count != DEPTH). When full, a pop does not enable a same-cycle push.
- Simultaneous push and pop when 0<count<DEPTH: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- flush: count<=0, pointers<=0, out_valid=0 next cycle. flush has priority over push/pop. rst has priority over flush.
- Decode on opcode = in_ir[6:2]. All sign extensions use in_ir[31] replicated to XLEN.
- LUI 01101 / AUIPC 00101: U, {ir[31:12],12'b0} sign-extended.
- JAL 11011: J, {ir[31],ir[19:12],ir[20],ir[30:21],0}.
- JALR 11001, LOAD 00000, MISC-MEM 00011: I, ir[31:20].
- BRANCH 11000: B, {ir[31],ir[7],ir[30:25],ir[11:8],0}.
- STORE 01000: S, {ir[31:25],ir[11:7]}.
- OP-IMM 00100:
  - funct3 001/101 gives SHAMT, zero-extended ir[24:20] for XLEN=32 and ir[25:20] for XLEN=64.
  - For XLEN=32, ir[25]=1 is illegal.
  - Any other funct3 gives I.
- OP-IMM-32 00110: XLEN=64 only; funct3 001/101 gives SHAMT ir[24:20], else I. For XLEN=32 the encoding is illegal.
- OP 01100, OP-32 01110 (XLEN=64 only): NONE, imm 0.
- SYSTEM 11100: funct3[2]=1 gives ZIMM, zero-extended ir[19:15]; else NONE, imm 0.
- Illegal whenever ir[1:0]!=2'b11 or the opcode is not listed above. Illegal entries get fmt NONE, imm 0, and are still buffered and delivered in order.
- Outputs are driven from the head entry only. Fields are held stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset then single push of in_ir=32'hFFF00093 (ADDI x1,x0,-1), pc=0x100, with out_ready=1. Required: out_valid rises next cycle with imm=0xFFFFFFFF, fmt=1, pc=0x100, illegal=0; out_valid falls the following cycle.
- XLEN=32, in_ir=32'h4041D093 (SRAI x1,x3,4). Required: imm=0x00000004, fmt=6. XLEN=64, in_ir=32'h43F1D093. Required: imm=0x3F, fmt=6.
- Branch 32'hFE000EE3 (BEQ offset -4). Required: imm=0xFFFFFFFC, fmt=3. JAL 32'h0080006F. Required: imm=8, fmt=5. CSRRWI 32'h3402D073. Required: imm=5, fmt=7.
- Backpressure, DEPTH=2, out_ready=0, push 3 back-to-back. Required: in_ready low after 2 accepted, 3rd held. Release out_ready: order preserved and the 3rd is accepted the cycle after the first pop.
- flush asserted with count=2 and a concurrent push. Required: out_valid=0 next cycle, in_ready=1, the pushed word never appears.
- in_ir=32'h00000000 (ir[1:0]=00) and opcode 11111. Required: illegal=1, fmt=0, imm=0, delivered in order. rst mid-stream. Required: all entries dropped, out_valid=0 next cycle.

Source files
------------

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate decoder feeding a small valid/ready FIFO with flush
module imm_gen_stage #(
  parameter int XLEN = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_ir,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 32 + 2 * XLEN + 4;
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0] op;
  logic [2:0] f3, fmt;
  logic sh, ill, push, pop;
  logic [XLEN-1:0] sx, imm;
  assign in_ready = cnt_q != CW'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign push = in_valid & in_ready & ~flush;
  assign pop = out_valid & out_ready & ~flush;
  assign {out_ir, out_pc, out_imm, out_fmt, out_illegal} = mem_q[rd_q];
  assign op = in_ir[6:2];
  assign f3 = in_ir[14:12];
  assign sh = f3[1:0] == 2'b01;
  assign sx = {XLEN{in_ir[31]}};
  always_comb begin
    imm = '0;
    fmt = 3'd0;
    ill = in_ir[1:0] != 2'b11;
    case (op)
      5'b01101, 5'b00101: begin
        fmt = 3'd4;
        imm = sx;
        imm[31:0] = {in_ir[31:12], 12'b0};
      end
      5'b11011: begin
        fmt = 3'd5;
        imm = sx;
        imm[20:0] = {in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
      end
      5'b11001, 5'b00000, 5'b00011: begin
        fmt = 3'd1;
        imm = sx;
        imm[11:0] = in_ir[31:20];
      end
      5'b11000: begin
        fmt = 3'd3;
        imm = sx;
        imm[12:0] = {in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
      end
      5'b01000: begin
        fmt = 3'd2;
        imm = sx;
        imm[11:0] = {in_ir[31:25], in_ir[11:7]};
      end
      5'b00100: begin
        fmt = sh ? 3'd6 : 3'd1;
        imm = sh ? '0 : sx;
        imm[11:0] = sh ? ((XLEN == 64) ? {6'b0, in_ir[25:20]} : {7'b0, in_ir[24:20]}) : in_ir[31:20];
        ill = ill | (sh & (XLEN == 32) & in_ir[25]);
      end
      5'b00110: begin
        fmt = sh ? 3'd6 : 3'd1;
        imm = sh ? '0 : sx;
        imm[11:0] = sh ? {7'b0, in_ir[24:20]} : in_ir[31:20];
        ill = ill | (XLEN != 64);
      end
      5'b01100: fmt = 3'd0;
      5'b01110: ill = ill | (XLEN != 64);
      5'b11100: begin
        fmt = f3[2] ? 3'd7 : 3'd0;
        imm[4:0] = f3[2] ? in_ir[19:15] : 5'd0;
      end
      default: ill = 1'b1;
    endcase
    imm = ill ? '0 : imm;
    fmt = ill ? 3'd0 : fmt;
  end
  always_comb begin
    cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    wr_d = flush ? '0 : push ? ((wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1)) : wr_q;
    rd_d = flush ? '0 : pop ? ((rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1)) : rd_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (push) mem_q[wr_q] <= {in_ir, in_pc, imm, fmt, ill};
    end
  end
endmodule
